// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage pipelined subtractor (a - b - bin) built from carry-select blocks.
// Stage 1 ripples the lower half and precomputes both upper-half candidates; stage 2 selects.
module carry_select_subtractor_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NBLK = HALF / BLOCK;

    if ((WIDTH % 2) != 0) begin : g_bad_width
        $error("WIDTH must be even");
    end
    if ((HALF % BLOCK) != 0) begin : g_bad_block
        $error("BLOCK must divide WIDTH/2");
    end

    // Subtraction as a + ~b + !bin; the final carry is the inverted borrow.
    logic [WIDTH-1:0] b_inv;
    logic             cin;

    assign b_inv = ~b;
    assign cin   = ~bin;

    // Lower half: plain ripple across blocks.
    logic [HALF-1:0] lo_sum;
    logic [NBLK:0]   lo_c;

    assign lo_c[0] = cin;

    for (genvar i = 0; i < NBLK; i++) begin : g_lo
        logic [BLOCK:0] s;
        assign s = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b_inv[i*BLOCK +: BLOCK]}
                 + {{BLOCK{1'b0}}, lo_c[i]};
        assign lo_sum[i*BLOCK +: BLOCK] = s[BLOCK-1:0];
        assign lo_c[i+1]                = s[BLOCK];
    end

    // Upper half: each block precomputes results for carry-in 0 and 1.
    logic [HALF-1:0] up_sum0;
    logic [HALF-1:0] up_sum1;
    logic [NBLK-1:0] up_c0;
    logic [NBLK-1:0] up_c1;

    for (genvar i = 0; i < NBLK; i++) begin : g_up
        logic [BLOCK:0] s0;
        logic [BLOCK:0] s1;
        assign s0 = {1'b0, a[HALF + i*BLOCK +: BLOCK]} + {1'b0, b_inv[HALF + i*BLOCK +: BLOCK]};
        assign s1 = {1'b0, a[HALF + i*BLOCK +: BLOCK]} + {1'b0, b_inv[HALF + i*BLOCK +: BLOCK]}
                  + {{BLOCK{1'b0}}, 1'b1};
        assign up_sum0[i*BLOCK +: BLOCK] = s0[BLOCK-1:0];
        assign up_sum1[i*BLOCK +: BLOCK] = s1[BLOCK-1:0];
        assign up_c0[i]                  = s0[BLOCK];
        assign up_c1[i]                  = s1[BLOCK];
    end

    // Handshake
    logic s1_valid_q;
    logic out_valid_q;
    logic adv1;
    logic adv2;

    assign adv2     = ~out_valid_q | out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign in_ready = adv1 & ~rst;

    // Stage 1 registers
    logic [HALF-1:0] s1_lo_diff_q;
    logic            s1_lo_c_q;
    logic [HALF-1:0] s1_sum0_q;
    logic [HALF-1:0] s1_sum1_q;
    logic [NBLK-1:0] s1_c0_q;
    logic [NBLK-1:0] s1_c1_q;
    logic            s1_a_msb_q;
    logic            s1_b_msb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_lo_diff_q <= '0;
            s1_lo_c_q    <= 1'b0;
            s1_sum0_q    <= '0;
            s1_sum1_q    <= '0;
            s1_c0_q      <= '0;
            s1_c1_q      <= '0;
            s1_a_msb_q   <= 1'b0;
            s1_b_msb_q   <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_lo_diff_q <= lo_sum;
                s1_lo_c_q    <= lo_c[NBLK];
                s1_sum0_q    <= up_sum0;
                s1_sum1_q    <= up_sum1;
                s1_c0_q      <= up_c0;
                s1_c1_q      <= up_c1;
                s1_a_msb_q   <= a[WIDTH-1];
                s1_b_msb_q   <= b[WIDTH-1];
            end
        end
    end

    // Stage 2: chain the block selects starting from the registered lower carry.
    logic [HALF-1:0]  up_diff;
    logic             carry;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;
    logic             ovf_d;
    logic             zero_d;

    always_comb begin
        up_diff = '0;
        carry   = s1_lo_c_q;
        for (int i = 0; i < NBLK; i++) begin
            if (carry) begin
                up_diff[i*BLOCK +: BLOCK] = s1_sum1_q[i*BLOCK +: BLOCK];
                carry                     = s1_c1_q[i];
            end else begin
                up_diff[i*BLOCK +: BLOCK] = s1_sum0_q[i*BLOCK +: BLOCK];
                carry                     = s1_c0_q[i];
            end
        end
        diff_d = {up_diff, s1_lo_diff_q};
        bout_d = ~carry;
        ovf_d  = (s1_a_msb_q ^ s1_b_msb_q) & (diff_d[WIDTH-1] ^ s1_a_msb_q);
        zero_d = ~|diff_d;
    end

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
